multicycle_stage_sequencer: RTL and testbench
=============================================

// Module: multicycle_stage_sequencer
// PURPOSE
//  Parametrised stage sequencer for the multicycle datapath: steps through NUM_STAGES stages.
//  Issues one-hot per-stage register enables.
//  Holds a memory stage until the memory interface returns MFC.
//  Converts memory errors and handshake timeouts into a sticky fault.
//  Sits between the memory interface (MEM_MFC/MEM_ERROR) and the per-stage register enables.
//  Counts retired instructions for the display unit.
// PARAMETERS
//  NUM_STAGES   5    stages per instruction, >=2
//  STAGE_W      3    width of Stage output; 2**STAGE_W > NUM_STAGES
//  FETCH_STAGE  1    stage that always performs a memory read (instruction fetch)
//  MEM_STAGE    4    stage that performs memory access when Mem_Access_Needed=1
//  TIMEOUT      255  max consecutive wait cycles before fault; 0 disables timeout
//  CNT_W        32   width of Instr_Count
// PORTS
//  Clock              in   1          rising-edge clock
//  Reset              in   1          synchronous, active-high
//  Run                in   1          1 = keep issuing instructions
//  Stall              in   1          freeze a non-memory stage
//  Mem_Access_Needed  in   1          current instruction uses memory in MEM_STAGE
//  MEM_MFC            in   1          memory function complete (data valid / write done)
//  MEM_ERROR          in   1          memory address not assigned
//  Stage              out  STAGE_W    current stage 1..NUM_STAGES; 0 when idle
//  Stage_Enable       out  NUM_STAGES one-hot; bit k = stage k+1 registers load this cycle
//  Mem_Request        out  1          memory access outstanding
//  Wait_State         out  1          Mem_Request & ~MEM_MFC
//  Fault              out  1          sticky fault indicator
//  Fault_Code         out  2          00 none, 01 timeout, 10 MEM_ERROR
//  Instr_Count        out  CNT_W      retired instructions, wraps modulo 2**CNT_W
// BEHAVIOUR
//  - One clock (Clock); Reset synchronous active-high.
//  - Reset values: state IDLE, Stage=0, Stage_Enable=0, Mem_Request=0, Fault=0, Fault_Code=00, Instr_Count=0, wait counter=0.
//  - FSM states: IDLE, RUN, FAULT.
//  - IDLE: outputs quiet. Run=1 at an edge -> RUN with Stage=1 in the next cycle.
//  - RUN, memory stage (Stage==FETCH_STAGE, or Stage==MEM_STAGE && Mem_Access_Needed):
//    - Mem_Request=1, derived combinationally from registered state.
//    - Stage_Enable bit asserts only in the cycle MEM_MFC=1; Stage advances at that edge.
//    - MFC already high in the entry cycle -> zero-wait advance.
//    - Stall is ignored in memory stages.
//  - RUN, non-memory stage: Stall=0 -> enable bit high for 1 cycle, Stage advances. Stall=1 -> enables 0, Stage holds.
//  - Advance from Stage==NUM_STAGES: Instr_Count+1, then Run=1 -> Stage=1, Run=0 -> IDLE (Stage=0).
//    - Run dropping mid-instruction completes the current instruction first.
//  - Wait counter: +1 each cycle with Mem_Request=1 && MEM_MFC=0; cleared on MFC or stage change.
//    - On reaching TIMEOUT -> FAULT, code 01, at that edge.
//  - MEM_ERROR=1 while Mem_Request=1 -> FAULT, code 10.
//    - MEM_ERROR takes priority over a simultaneous MEM_MFC or timeout.
//    - MEM_ERROR is ignored when Mem_Request=0.
//  - FAULT: Stage holds the faulting stage, Stage_Enable=0, Mem_Request=0, Fault=1. Left only by Reset.
//  - Reset mid-operation (including during a wait): all reset values at the next edge; Mem_Request drops.
//  - Elaboration check: FETCH_STAGE != MEM_STAGE, both in 1..NUM_STAGES.
// STRUCTURE
//  - Package sequencer_pkg: state encoding (IDLE/RUN/FAULT), FAULT_NONE/TIMEOUT/MEMERR constants.
//  - Sub-module wait_timeout_counter: clear/inc/expired, parametrised by TIMEOUT.
//  - Remainder: FSM, stage counter, one-hot decode, instruction counter.
// TESTING
//  1. Reset; Run=1; MEM_MFC=1 always; Mem_Access_Needed=0 -> Stage 1,2,3,4,5,1 on consecutive cycles; Instr_Count=1 after 5th.
//  2. Fetch MFC delayed 3 cycles -> Stage=1 for 4 cycles; Wait_State=1 for 3; Stage_Enable[0] only in MFC cycle.
//  3. TIMEOUT=8, MFC never -> Fault=1, Fault_Code=01 after 8 wait cycles; Stage=1; Mem_Request=0.
//  4. Mem_Access_Needed=1; MEM_ERROR+MEM_MFC together at stage 4 -> Fault_Code=10; Stage=4; no Stage_Enable[3].
//  5. Stall=1 two cycles at stage 3; Run=0 during stage 2 -> Stage 3 held 3 cycles; reaches 5, then Stage=0; Instr_Count+1.
//  6. CNT_W=4, 16 instructions -> Instr_Count wraps to 0. Reset during stage-4 wait -> all outputs 0 next cycle.

Source files
------------

// File: rtl/sequencer_pkg.sv
// Shared types and constants for the multicycle stage sequencer.
package sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } seq_state_t;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b01;
    localparam logic [1:0] FAULT_MEMERR  = 2'b10;

endpackage

// File: rtl/wait_timeout_counter.sv
// Counts consecutive memory wait cycles and flags the cycle in which the
// count would reach TIMEOUT. TIMEOUT=0 disables expiry.
module wait_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    logic [CW-1:0] count;

    // Wait-cycle count: cleared whenever the handshake is not waiting, holds at LAST
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc && (TIMEOUT != 0) && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    // Expiry fires on the wait cycle that would bring the count up to TIMEOUT
    assign expired = (TIMEOUT != 0) && inc && (count == LAST);

endmodule

// File: rtl/multicycle_stage_sequencer.sv
// Stage sequencer for the multicycle datapath: steps through NUM_STAGES
// stages, issues one-hot stage register enables, holds memory stages until
// MEM_MFC, turns memory errors and handshake timeouts into a sticky fault,
// and counts retired instructions.
module multicycle_stage_sequencer
    import sequencer_pkg::*;
#(
    parameter int NUM_STAGES  = 5,
    parameter int STAGE_W     = 3,
    parameter int FETCH_STAGE = 1,
    parameter int MEM_STAGE   = 4,
    parameter int TIMEOUT     = 255,
    parameter int CNT_W       = 32
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Run,
    input  logic                  Stall,
    input  logic                  Mem_Access_Needed,
    input  logic                  MEM_MFC,
    input  logic                  MEM_ERROR,
    output logic [STAGE_W-1:0]    Stage,
    output logic [NUM_STAGES-1:0] Stage_Enable,
    output logic                  Mem_Request,
    output logic                  Wait_State,
    output logic                  Fault,
    output logic [1:0]            Fault_Code,
    output logic [CNT_W-1:0]      Instr_Count
);

    generate
        if ((NUM_STAGES < 2) || ((2 ** STAGE_W) <= NUM_STAGES) ||
            (FETCH_STAGE == MEM_STAGE) ||
            (FETCH_STAGE < 1) || (FETCH_STAGE > NUM_STAGES) ||
            (MEM_STAGE < 1) || (MEM_STAGE > NUM_STAGES)) begin : g_bad_params
            $error("multicycle_stage_sequencer: illegal stage parameters");
        end
    endgenerate

    localparam logic [STAGE_W-1:0] FIRST_S = STAGE_W'(1);
    localparam logic [STAGE_W-1:0] LAST_S  = STAGE_W'(NUM_STAGES);
    localparam logic [STAGE_W-1:0] FETCH_S = STAGE_W'(FETCH_STAGE);
    localparam logic [STAGE_W-1:0] MEM_S   = STAGE_W'(MEM_STAGE);

    seq_state_t         state, state_n;
    logic [STAGE_W-1:0] stage_q, stage_n;
    logic [1:0]         code_q, code_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic               mem_stage;
    logic               advance;
    logic               wait_inc;
    logic               wait_expired;

    // Stage classification, advance condition and one-hot enable decode
    always_comb begin
        mem_stage    = (state == ST_RUN) &&
                       ((stage_q == FETCH_S) || ((stage_q == MEM_S) && Mem_Access_Needed));
        advance      = (state == ST_RUN) &&
                       (mem_stage ? (MEM_MFC && !MEM_ERROR) : !Stall);
        wait_inc     = mem_stage && !MEM_MFC;
        Stage_Enable = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            Stage_Enable[k] = advance && (stage_q == STAGE_W'(k + 1));
        end
    end

    // Any cycle that is not a pending wait (MFC seen, stage moved, or no request) restarts the count
    wait_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_wait (
        .clk     (Clock),
        .rst     (Reset),
        .clear   (!wait_inc),
        .inc     (wait_inc),
        .expired (wait_expired)
    );

    // Next-state: MEM_ERROR outranks timeout, which outranks a normal advance
    always_comb begin
        state_n = state;
        stage_n = stage_q;
        code_n  = code_q;
        cnt_n   = cnt_q;
        case (state)
            ST_IDLE: begin
                if (Run) begin
                    state_n = ST_RUN;
                    stage_n = FIRST_S;
                end
            end
            ST_RUN: begin
                if (mem_stage && MEM_ERROR) begin
                    state_n = ST_FAULT;
                    code_n  = FAULT_MEMERR;
                end else if (wait_expired) begin
                    state_n = ST_FAULT;
                    code_n  = FAULT_TIMEOUT;
                end else if (advance) begin
                    if (stage_q == LAST_S) begin
                        cnt_n = cnt_q + 1'b1;
                        if (Run) begin
                            stage_n = FIRST_S;
                        end else begin
                            state_n = ST_IDLE;
                            stage_n = '0;
                        end
                    end else begin
                        stage_n = stage_q + 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                state_n = ST_FAULT;
            end
            default: begin
                state_n = ST_IDLE;
                stage_n = '0;
            end
        endcase
    end

    // State, stage, fault code and retired-instruction registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= ST_IDLE;
            stage_q <= '0;
            code_q  <= FAULT_NONE;
            cnt_q   <= '0;
        end else begin
            state   <= state_n;
            stage_q <= stage_n;
            code_q  <= code_n;
            cnt_q   <= cnt_n;
        end
    end

    assign Stage       = stage_q;
    assign Mem_Request = mem_stage;
    assign Wait_State  = wait_inc;
    assign Fault       = (state == ST_FAULT);
    assign Fault_Code  = code_q;
    assign Instr_Count = cnt_q;

endmodule

// File: tb/tb_multicycle_stage_sequencer.sv
// Table-driven bench for multicycle_stage_sequencer (TIMEOUT=8, CNT_W=4).
module tb_multicycle_stage_sequencer;

    logic       clk = 1'b0;
    logic       Reset, Run, Stall, Mem_Access_Needed, MEM_MFC, MEM_ERROR;
    logic [2:0] Stage;
    logic [4:0] Stage_Enable;
    logic       Mem_Request, Wait_State, Fault;
    logic [1:0] Fault_Code;
    logic [3:0] Instr_Count;

    always #5 clk = ~clk;

    multicycle_stage_sequencer #(
        .NUM_STAGES  (5),
        .STAGE_W     (3),
        .FETCH_STAGE (1),
        .MEM_STAGE   (4),
        .TIMEOUT     (8),
        .CNT_W       (4)
    ) dut (
        .Clock             (clk),
        .Reset             (Reset),
        .Run               (Run),
        .Stall             (Stall),
        .Mem_Access_Needed (Mem_Access_Needed),
        .MEM_MFC           (MEM_MFC),
        .MEM_ERROR         (MEM_ERROR),
        .Stage             (Stage),
        .Stage_Enable      (Stage_Enable),
        .Mem_Request       (Mem_Request),
        .Wait_State        (Wait_State),
        .Fault             (Fault),
        .Fault_Code        (Fault_Code),
        .Instr_Count       (Instr_Count)
    );

    // in = {rst, run, stall, man, mfc, err}
    typedef struct {
        logic [5:0] in;
        logic [2:0] stage;
        logic [4:0] en;
        logic       req;
        logic       wt;
        logic       flt;
        logic [1:0] code;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(logic [5:0] in, logic [2:0] st, logic [4:0] en,
                                logic req, logic wt, logic flt,
                                logic [1:0] code, logic [3:0] cnt);
        vec_t v;
        v.in = in; v.stage = st; v.en = en; v.req = req;
        v.wt = wt; v.flt = flt; v.code = code; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, ".stage"}, 32'(Stage), 32'(v.stage));
        chk({tag, ".enable"}, 32'(Stage_Enable), 32'(v.en));
        chk({tag, ".mem_req"}, 32'(Mem_Request), 32'(v.req));
        chk({tag, ".wait"}, 32'(Wait_State), 32'(v.wt));
        chk({tag, ".fault"}, 32'(Fault), 32'(v.flt));
        chk({tag, ".code"}, 32'(Fault_Code), 32'(v.code));
        chk({tag, ".count"}, 32'(Instr_Count), 32'(v.cnt));
    endtask

    initial begin
        // basic run, all MFC immediate: stages 1..5 then 1, count 1
        vecs.push_back(mk(6'b010010, 3'd0, 5'b00000, 0, 0, 0, 2'd0, 4'd0));
        vecs.push_back(mk(6'b010010, 3'd1, 5'b00001, 1, 0, 0, 2'd0, 4'd0));
        vecs.push_back(mk(6'b010010, 3'd2, 5'b00010, 0, 0, 0, 2'd0, 4'd0));
        vecs.push_back(mk(6'b010010, 3'd3, 5'b00100, 0, 0, 0, 2'd0, 4'd0));
        vecs.push_back(mk(6'b010010, 3'd4, 5'b01000, 0, 0, 0, 2'd0, 4'd0));
        vecs.push_back(mk(6'b010010, 3'd5, 5'b10000, 0, 0, 0, 2'd0, 4'd0));
        vecs.push_back(mk(6'b010010, 3'd1, 5'b00001, 1, 0, 0, 2'd0, 4'd1));
        vecs.push_back(mk(6'b101010, 3'd2, 5'b00000, 0, 0, 0, 2'd0, 4'd1));
        // fetch MFC delayed 3 cycles; then Run drops in stage 2, Stall twice in stage 3
        vecs.push_back(mk(6'b010001, 3'd0, 5'b00000, 0, 0, 0, 2'd0, 4'd0));
        vecs.push_back(mk(6'b010000, 3'd1, 5'b00000, 1, 1, 0, 2'd0, 4'd0));
        vecs.push_back(mk(6'b010000, 3'd1, 5'b00000, 1, 1, 0, 2'd0, 4'd0));
        vecs.push_back(mk(6'b010000, 3'd1, 5'b00000, 1, 1, 0, 2'd0, 4'd0));
        vecs.push_back(mk(6'b010010, 3'd1, 5'b00001, 1, 0, 0, 2'd0, 4'd0));
        vecs.push_back(mk(6'b000010, 3'd2, 5'b00010, 0, 0, 0, 2'd0, 4'd0));
        vecs.push_back(mk(6'b001011, 3'd3, 5'b00000, 0, 0, 0, 2'd0, 4'd0));
        vecs.push_back(mk(6'b001010, 3'd3, 5'b00000, 0, 0, 0, 2'd0, 4'd0));
        vecs.push_back(mk(6'b000010, 3'd3, 5'b00100, 0, 0, 0, 2'd0, 4'd0));
        vecs.push_back(mk(6'b000010, 3'd4, 5'b01000, 0, 0, 0, 2'd0, 4'd0));
        vecs.push_back(mk(6'b000010, 3'd5, 5'b10000, 0, 0, 0, 2'd0, 4'd0));
        vecs.push_back(mk(6'b000010, 3'd0, 5'b00000, 0, 0, 0, 2'd0, 4'd1));
        vecs.push_back(mk(6'b000010, 3'd0, 5'b00000, 0, 0, 0, 2'd0, 4'd1));
        // memory stage 4: MEM_ERROR with MFC -> fault code 10, no stage-4 enable
        vecs.push_back(mk(6'b100000, 3'd0, 5'b00000, 0, 0, 0, 2'd0, 4'd1));
        vecs.push_back(mk(6'b011110, 3'd0, 5'b00000, 0, 0, 0, 2'd0, 4'd0));
        vecs.push_back(mk(6'b011110, 3'd1, 5'b00001, 1, 0, 0, 2'd0, 4'd0));
        vecs.push_back(mk(6'b010110, 3'd2, 5'b00010, 0, 0, 0, 2'd0, 4'd0));
        vecs.push_back(mk(6'b010110, 3'd3, 5'b00100, 0, 0, 0, 2'd0, 4'd0));
        vecs.push_back(mk(6'b010100, 3'd4, 5'b00000, 1, 1, 0, 2'd0, 4'd0));
        vecs.push_back(mk(6'b010111, 3'd4, 5'b00000, 1, 0, 0, 2'd0, 4'd0));
        vecs.push_back(mk(6'b010110, 3'd4, 5'b00000, 0, 0, 1, 2'd2, 4'd0));
        vecs.push_back(mk(6'b010010, 3'd4, 5'b00000, 0, 0, 1, 2'd2, 4'd0));
        // fetch timeout after 8 wait cycles -> fault code 01 in stage 1
        vecs.push_back(mk(6'b100000, 3'd4, 5'b00000, 0, 0, 1, 2'd2, 4'd0));
        vecs.push_back(mk(6'b010000, 3'd0, 5'b00000, 0, 0, 0, 2'd0, 4'd0));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(6'b010000, 3'd1, 5'b00000, 1, 1, 0, 2'd0, 4'd0));
        vecs.push_back(mk(6'b010000, 3'd1, 5'b00000, 0, 0, 1, 2'd1, 4'd0));
        // reset during a stage-4 wait clears everything at the next edge
        vecs.push_back(mk(6'b100000, 3'd1, 5'b00000, 0, 0, 1, 2'd1, 4'd0));
        vecs.push_back(mk(6'b010110, 3'd0, 5'b00000, 0, 0, 0, 2'd0, 4'd0));
        vecs.push_back(mk(6'b010110, 3'd1, 5'b00001, 1, 0, 0, 2'd0, 4'd0));
        vecs.push_back(mk(6'b010110, 3'd2, 5'b00010, 0, 0, 0, 2'd0, 4'd0));
        vecs.push_back(mk(6'b010110, 3'd3, 5'b00100, 0, 0, 0, 2'd0, 4'd0));
        vecs.push_back(mk(6'b010100, 3'd4, 5'b00000, 1, 1, 0, 2'd0, 4'd0));
        vecs.push_back(mk(6'b110100, 3'd4, 5'b00000, 1, 1, 0, 2'd0, 4'd0));
        vecs.push_back(mk(6'b000000, 3'd0, 5'b00000, 0, 0, 0, 2'd0, 4'd0));

        Reset = 1'b1; Run = 1'b0; Stall = 1'b0;
        Mem_Access_Needed = 1'b0; MEM_MFC = 1'b0; MEM_ERROR = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        Reset = 1'b0;
        #1;
        chk_all("reset", mk(6'b000000, 3'd0, 5'b00000, 0, 0, 0, 2'd0, 4'd0));

        foreach (vecs[i]) begin
            {Reset, Run, Stall, Mem_Access_Needed, MEM_MFC, MEM_ERROR} = vecs[i].in;
            #2;
            chk_all($sformatf("row%0d", i), vecs[i]);
            @(posedge clk);
            #1;
        end

        // counter wrap: 16 back-to-back instructions with 4-bit count
        Reset = 1'b1; Run = 1'b0; Stall = 1'b0;
        Mem_Access_Needed = 1'b0; MEM_MFC = 1'b1; MEM_ERROR = 1'b0;
        @(posedge clk);
        #1;
        Reset = 1'b0;
        Run   = 1'b1;
        repeat (1 + 5 * 15) @(posedge clk);
        #1;
        chk("wrap.count15", 32'(Instr_Count), 32'd15);
        chk("wrap.stage15", 32'(Stage), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("wrap.count0", 32'(Instr_Count), 32'd0);
        chk("wrap.stage0", 32'(Stage), 32'd1);
        chk("wrap.enable0", 32'(Stage_Enable), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
